piece_bag: RTL and testbench

Consumes the free-running 10-bit pseudo-random word from the game's random number generator and turns it into a fair "7-bag" tetromino sequence. Every group of seven draws contains each piece index 0..6 exactly once. The block sits between the random generator and the game-logic spawn FSM, which requests one piece at a time over a req/valid handshake.

---
 rtl/piece_bag_if.sv | 27 ++
 rtl/piece_bag.sv | 137 +++++++++++++
 tb/tb_piece_bag.sv | 137 +++++++++++++
 3 files changed

// File: rtl/piece_bag_if.sv
// Handshake bundle between the random source / spawn FSM and the piece bag.
interface piece_bag_if;
  logic [9:0] rnd;
  logic       req;
  logic [2:0] piece;
  logic       valid;
  logic       busy;
  logic [2:0] remaining;

  modport master (
    output rnd,
    output req,
    input  piece,
    input  valid,
    input  busy,
    input  remaining
  );

  modport slave (
    input  rnd,
    input  req,
    output piece,
    output valid,
    output busy,
    output remaining
  );
endinterface

// File: rtl/piece_bag.sv
// 7-bag tetromino generator: draws each piece once per bag using rejection
// sampling of the random word, with a lowest-free-piece fallback after
// MAXTRY rejected samples.
module piece_bag #(
  parameter int NPIECE = 7,
  parameter int MAXTRY = 7
) (
  input  logic         clk,
  input  logic         reset,
  piece_bag_if.slave   bag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [NPIECE-1:0] FULL_MASK = {NPIECE{1'b1}};
  localparam logic [2:0]        MAXTRY_C  = 3'(MAXTRY);

  state_t            state_q, state_d;
  logic [NPIECE-1:0] mask_q, mask_d;
  logic [2:0]        try_q, try_d;
  logic [2:0]        piece_q, piece_d;

  logic [2:0]        cand_s;
  logic [NPIECE:0]   avail_s;
  logic              take_s;
  logic [2:0]        take_idx_s;
  logic [NPIECE-1:0] mask_clr_s;
  logic              unused_rnd_s;

  // Number of set bits in the availability mask.
  function automatic logic [2:0] popcount(input logic [NPIECE-1:0] m);
    logic [2:0] acc;
    acc = 3'd0;
    for (int i = 0; i < NPIECE; i++) begin
      acc = acc + {2'd0, m[i]};
    end
    return acc;
  endfunction

  // Index of the lowest set bit; the mask is never empty when this is used.
  function automatic logic [2:0] lowest_set(input logic [NPIECE-1:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NPIECE - 1; i >= 0; i--) begin
      if (m[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Middle bits of the random word do not take part in the candidate.
  assign unused_rnd_s = &{1'b0, bag.rnd[6:3]};

  assign cand_s  = bag.rnd[2:0] ^ bag.rnd[9:7];
  // Extra always-zero top bit makes candidate code 7 read as unavailable.
  assign avail_s = {1'b0, mask_q};

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= FULL_MASK;
      try_q   <= 3'd0;
      piece_q <= 3'd0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      try_q   <= try_d;
      piece_q <= piece_d;
    end
  end

  // Next-state logic: accept, retry or fall back, then clear/refill the mask.
  always_comb begin
    state_d    = state_q;
    try_d      = try_q;
    piece_d    = piece_q;
    mask_d     = mask_q;
    take_s     = 1'b0;
    take_idx_s = 3'd0;
    mask_clr_s = mask_q;
    case (state_q)
      IDLE: begin
        if (bag.req) begin
          state_d = DRAW;
          try_d   = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        if (avail_s[cand_s]) begin
          take_s     = 1'b1;
          take_idx_s = cand_s;
        end else if (try_q < MAXTRY_C) begin
          try_d = try_q + 3'd1;
        end else begin
          take_s     = 1'b1;
          take_idx_s = lowest_set(mask_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_s) begin
      piece_d    = take_idx_s;
      state_d    = DONE;
      mask_clr_s = mask_q & ~(NPIECE'(1) << take_idx_s);
      if (mask_clr_s == '0) begin
        mask_d = FULL_MASK;
      end else begin
        mask_d = mask_clr_s;
      end
    end else begin
      mask_d = mask_q;
    end
  end

  // Output decode from registered state, piece and mask.
  always_comb begin
    bag.piece     = piece_q;
    bag.valid     = (state_q == DONE);
    bag.busy      = (state_q != IDLE);
    bag.remaining = popcount(mask_q);
  end

endmodule

// File: tb/tb_piece_bag.sv
// Directed self-checking bench for piece_bag.
module tb_piece_bag;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  piece_bag_if bag_if ();

  piece_bag #(.NPIECE(7), .MAXTRY(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bag   (bag_if.slave)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete draw: pulse req with rnd held, wait for valid, check result.
  task automatic do_draw(input string tag, input logic [9:0] r, input int exp_cyc,
                         input logic [2:0] exp_piece, input logic [2:0] exp_rem);
    int n;
    bag_if.rnd = r;
    bag_if.req = 1'b1;
    tick();
    bag_if.req = 1'b0;
    check_val({tag, "_busy_draw"}, {31'd0, bag_if.busy}, 32'd1);
    n = 0;
    while (bag_if.valid !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
    check_val({tag, "_latency"}, n, exp_cyc);
    check_val({tag, "_piece"}, {29'd0, bag_if.piece}, {29'd0, exp_piece});
    check_val({tag, "_remaining"}, {29'd0, bag_if.remaining}, {29'd0, exp_rem});
    check_val({tag, "_busy_done"}, {31'd0, bag_if.busy}, 32'd1);
    tick();
    check_val({tag, "_valid_drop"}, {31'd0, bag_if.valid}, 32'd0);
    check_val({tag, "_idle"}, {31'd0, bag_if.busy}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bag_if.rnd = 10'h000;
    bag_if.req = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check_val("rst_piece", {29'd0, bag_if.piece}, 32'd0);
    check_val("rst_valid", {31'd0, bag_if.valid}, 32'd0);
    check_val("rst_busy", {31'd0, bag_if.busy}, 32'd0);
    check_val("rst_remaining", {29'd0, bag_if.remaining}, 32'd7);

    // Single accept, then exhausted-retry fallback, then code-7 rejection.
    do_draw("accept3", 10'h003, 1, 3'd3, 3'd6);
    do_draw("fallback", 10'h003, 8, 3'd0, 3'd5);

    bag_if.rnd = 10'h007;
    bag_if.req = 1'b1;
    tick();
    bag_if.req = 1'b0;
    tick();
    check_val("code7_reject_valid", {31'd0, bag_if.valid}, 32'd0);
    check_val("code7_reject_busy", {31'd0, bag_if.busy}, 32'd1);
    bag_if.rnd = 10'h005;
    tick();
    check_val("code7_valid", {31'd0, bag_if.valid}, 32'd1);
    check_val("code7_piece", {29'd0, bag_if.piece}, 32'd5);
    check_val("code7_remaining", {29'd0, bag_if.remaining}, 32'd4);
    tick();

    // Asynchronous reset between edges restores a full bag immediately.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst2_piece", {29'd0, bag_if.piece}, 32'd0);
    check_val("rst2_valid", {31'd0, bag_if.valid}, 32'd0);
    check_val("rst2_busy", {31'd0, bag_if.busy}, 32'd0);
    check_val("rst2_remaining", {29'd0, bag_if.remaining}, 32'd7);
    tick();
    reset = 1'b0;

    // Full bag in order, refill on the seventh draw, then an eighth draw.
    for (int i = 0; i < 7; i++) begin
      logic [2:0] er;
      er = (i == 6) ? 3'd7 : 3'(6 - i);
      do_draw($sformatf("bag%0d", i), 10'(i), 1, 3'(i), er);
    end
    do_draw("refill_draw", 10'h002, 1, 3'd2, 3'd6);

    // Reset while stuck rejecting code 7: no valid, bag restored.
    bag_if.rnd = 10'h007;
    bag_if.req = 1'b1;
    tick();
    bag_if.req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check_val("middraw_no_valid", {31'd0, bag_if.valid}, 32'd0);
      tick();
    end
    check_val("middraw_busy", {31'd0, bag_if.busy}, 32'd1);
    check_val("middraw_rem_before", {29'd0, bag_if.remaining}, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    check_val("middraw_valid", {31'd0, bag_if.valid}, 32'd0);
    check_val("middraw_busy_rst", {31'd0, bag_if.busy}, 32'd0);
    check_val("middraw_remaining", {29'd0, bag_if.remaining}, 32'd7);
    tick();
    #2;
    reset = 1'b0;
    tick();
    do_draw("after_rst", 10'h001, 1, 3'd1, 3'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
